// File: rtl/exe_mem_elastic_reg.sv
// exe_mem_elastic_reg: elastic EXE->MEM pipeline register.
// Carries MEM_R_EN/MEM_W_EN/WB_EN, Dest, ALU_Res and Val_Rm from EXE to MEM
// behind a valid/ready handshake. With SKID_EN=1 a second (skid) entry lets
// in_ready come straight from a flop, so a MEM stall never creates a
// combinational ready path back into EXE. With SKID_EN=0 the stage holds a
// single entry and in_ready = out_ready | ~out_valid.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   flush             drop every held entry (and any same-cycle input)
//   in_valid/in_ready EXE-side handshake
//   *_in              control bits, destination and data from EXE
//   out_valid/out_ready MEM-side handshake
//   *_out             head entry; control bits are gated by out_valid
//   fwd_wb_en/fwd_dest forwarding tap from the head entry
module exe_mem_elastic_reg #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned REG_FILE_DEPTH = 4,
  parameter int unsigned SKID_EN        = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      MEM_R_EN_in,
  input  logic                      MEM_W_EN_in,
  input  logic                      WB_EN_in,
  input  logic [REG_FILE_DEPTH-1:0] Dest_in,
  input  logic [WORD_WIDTH-1:0]     ALU_Res_in,
  input  logic [WORD_WIDTH-1:0]     Val_Rm_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      MEM_R_EN_out,
  output logic                      MEM_W_EN_out,
  output logic                      WB_EN_out,
  output logic [REG_FILE_DEPTH-1:0] Dest_out,
  output logic [WORD_WIDTH-1:0]     ALU_Res_out,
  output logic [WORD_WIDTH-1:0]     Val_Rm_out,
  output logic                      fwd_wb_en,
  output logic [REG_FILE_DEPTH-1:0] fwd_dest
);

  // Entry layout: {MEM_R_EN, MEM_W_EN, WB_EN, Dest, ALU_Res, Val_Rm}
  localparam int unsigned ENTRY_W = 3 + REG_FILE_DEPTH + 2 * WORD_WIDTH;
  localparam int unsigned DATA_W  = REG_FILE_DEPTH + 2 * WORD_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_h_valid;
  logic               r_s_valid;
  logic               r_in_ready;
  logic [ENTRY_W-1:0] r_h_entry;
  logic [ENTRY_W-1:0] r_s_entry;

  logic               w_in_fire;
  logic               w_out_fire;
  logic [ENTRY_W-1:0] w_in_entry;

  assign w_in_entry = {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Dest_in, ALU_Res_in, Val_Rm_in};

  // Skid variant: ready is a flop; single-entry variant: classic pass-through ready.
  assign in_ready   = (SKID_EN != 0) ? r_in_ready : (out_ready | ~r_h_valid);
  assign out_valid  = r_h_valid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_h_valid & out_ready;

  // Occupancy state, valid bits, ready flop and entry storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_EMPTY;
      r_h_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
      r_h_entry  <= '0;
      r_s_entry  <= '0;
    end else if (flush) begin
      // Held entries are dropped; a same-cycle input is dropped too.
      r_state    <= ST_EMPTY;
      r_h_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_h_entry <= w_in_entry;
            r_h_valid <= 1'b1;
            r_state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            // Only reachable with a skid slot; park the new entry behind H.
            if (SKID_EN != 0) begin
              r_s_entry  <= w_in_entry;
              r_s_valid  <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= ST_FULL;
            end
          end else if (w_in_fire && w_out_fire) begin
            r_h_entry <= w_in_entry;
          end else if (w_out_fire) begin
            r_h_valid <= 1'b0;
            r_state   <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the head can move.
          if (w_out_fire) begin
            r_h_entry  <= r_s_entry;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_h_valid  <= 1'b0;
          r_s_valid  <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Control bits are gated so a bubble never issues a memory access or writeback.
  assign MEM_R_EN_out = r_h_entry[ENTRY_W-1] & r_h_valid;
  assign MEM_W_EN_out = r_h_entry[ENTRY_W-2] & r_h_valid;
  assign WB_EN_out    = r_h_entry[ENTRY_W-3] & r_h_valid;
  assign Dest_out     = r_h_entry[DATA_W-1 -: REG_FILE_DEPTH];
  assign ALU_Res_out  = r_h_entry[2*WORD_WIDTH-1 -: WORD_WIDTH];
  assign Val_Rm_out   = r_h_entry[WORD_WIDTH-1:0];

  // S valid implies H valid, so the head alone drives the forwarding tap.
  assign fwd_dest     = r_h_entry[DATA_W-1 -: REG_FILE_DEPTH];
  assign fwd_wb_en    = r_h_entry[ENTRY_W-3] & r_h_valid;

endmodule

// File: tb/tb_exe_mem_elastic_reg.sv
// Bench for exe_mem_elastic_reg: scoreboard on the skid instance, directed
// checks on a single-entry (SKID_EN=0) instance.
module tb_exe_mem_elastic_reg;

  typedef struct packed {
    logic        r;
    logic        w;
    logic        wb;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] rm;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        r_in, w_in, wb_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_in, rm_in;
  logic        r_out, w_out, wb_out, fwd_wb_en;
  logic [3:0]  dest_out, fwd_dest;
  logic [31:0] alu_out, rm_out;

  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic        r_out0, w_out0, wb_out0, fwd_wb_en0;
  logic [3:0]  dest_out0, fwd_dest0;
  logic [31:0] alu_out0, rm_out0;

  int   n_cmp  = 0;
  int   n_fail = 0;
  ent_t q[$];
  ent_t cur;

  always #5 clk = ~clk;

  exe_mem_elastic_reg #(.WORD_WIDTH(32), .REG_FILE_DEPTH(4), .SKID_EN(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .MEM_R_EN_in(r_in), .MEM_W_EN_in(w_in), .WB_EN_in(wb_in),
    .Dest_in(dest_in), .ALU_Res_in(alu_in), .Val_Rm_in(rm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .MEM_R_EN_out(r_out), .MEM_W_EN_out(w_out), .WB_EN_out(wb_out),
    .Dest_out(dest_out), .ALU_Res_out(alu_out), .Val_Rm_out(rm_out),
    .fwd_wb_en(fwd_wb_en), .fwd_dest(fwd_dest)
  );

  exe_mem_elastic_reg #(.WORD_WIDTH(32), .REG_FILE_DEPTH(4), .SKID_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .MEM_R_EN_in(r_in), .MEM_W_EN_in(w_in), .WB_EN_in(wb_in),
    .Dest_in(dest_in), .ALU_Res_in(alu_in), .Val_Rm_in(rm_in),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .MEM_R_EN_out(r_out0), .MEM_W_EN_out(w_out0), .WB_EN_out(wb_out0),
    .Dest_out(dest_out0), .ALU_Res_out(alu_out0), .Val_Rm_out(rm_out0),
    .fwd_wb_en(fwd_wb_en0), .fwd_dest(fwd_dest0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input ent_t e, input logic v);
    cur      = e;
    in_valid = v;
    r_in     = e.r;
    w_in     = e.w;
    wb_in    = e.wb;
    dest_in  = e.dest;
    alu_in   = e.alu;
    rm_in    = e.rm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the current input until the DUT takes it, then record it as expected.
  task automatic accept_wait(input string name);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        q.push_back(cur);
        done = 1'b1;
      end else if (n >= 20) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s: in_ready never rose within 20 cycles", name);
        done = 1'b1;
      end
      n++;
      step();
    end
  endtask

  // Monitor: every head transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got alu 0x%0h dest %0d, expected nothing", alu_out, dest_out);
      end else begin
        ent_t e;
        e = q.pop_front();
        check("out_alu",  64'(alu_out), 64'(e.alu));
        check("out_rm",   64'(rm_out), 64'(e.rm));
        check("out_dest", 64'(dest_out), 64'(e.dest));
        check("out_ctrl", 64'({r_out, w_out, wb_out}), 64'({e.r, e.w, e.wb}));
        check("fwd_tap",  64'({fwd_wb_en, fwd_dest}), 64'({e.wb, e.dest}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam ent_t STREAM [3] = '{
    '{r: 1'b1, w: 1'b0, wb: 1'b1, dest: 4'd1, alu: 32'h10, rm: 32'h1111},
    '{r: 1'b0, w: 1'b1, wb: 1'b0, dest: 4'd2, alu: 32'h20, rm: 32'h2222},
    '{r: 1'b0, w: 1'b0, wb: 1'b1, dest: 4'd3, alu: 32'h30, rm: 32'h3333}
  };

  initial begin
    ent_t e;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1;
    e = '{r: 1'b1, w: 1'b1, wb: 1'b1, dest: 4'd9, alu: 32'h55, rm: 32'h66};
    drive(e, 1'b1);

    // Reset for two edges with in_valid high: nothing may be captured.
    step(); step();
    rst = 1'b1;
    drive(e, 1'b0);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_data",      64'({alu_out, rm_out}), 64'd0);
    check("rst_ctrl",      64'({r_out, w_out, wb_out, dest_out, fwd_wb_en, fwd_dest}), 64'd0);
    check("rst_in_ready0", 64'(in_ready0), 64'd1);
    check("rst_out_valid0", 64'(out_valid0), 64'd0);
    step();

    // Streaming: three back-to-back entries, each visible one cycle later.
    for (int i = 0; i < 3; i++) begin
      drive(STREAM[i], 1'b1);
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) begin
        check("stream_valid", 64'(out_valid), 64'd1);
        check("stream_prev",  64'(alu_out), 64'(STREAM[i-1].alu));
      end
      q.push_back(STREAM[i]);
      step();
    end
    drive(STREAM[2], 1'b0);
    @(negedge clk);
    check("stream_last_valid", 64'(out_valid), 64'd1);
    check("stream_last_alu",   64'(alu_out), 64'h30);
    step();
    @(negedge clk);
    check("stream_drained", 64'(out_valid), 64'd0);
    step();

    // Backpressure: 0xA to H, 0xB to S, 0xC waits, then drain in order.
    out_ready = 1'b0;
    drive('{r: 1'b0, w: 1'b1, wb: 1'b1, dest: 4'd10, alu: 32'hA, rm: 32'hA0}, 1'b1);
    accept_wait("bp_a");
    drive('{r: 1'b1, w: 1'b0, wb: 1'b1, dest: 4'd11, alu: 32'hB, rm: 32'hB0}, 1'b1);
    accept_wait("bp_b");
    drive('{r: 1'b1, w: 1'b1, wb: 1'b0, dest: 4'd12, alu: 32'hC, rm: 32'hC0}, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_full_in_ready", 64'(in_ready), 64'd0);
      check("bp_head_alu",      64'(alu_out), 64'hA);
      check("bp_fwd",           64'({fwd_wb_en, fwd_dest}), 64'({1'b1, 4'd10}));
      step();
    end
    out_ready = 1'b1;
    accept_wait("bp_c");
    drive(cur, 1'b0);
    repeat (3) step();
    check("bp_queue_empty", 64'(q.size()), 64'd0);

    // Flush while FULL with a same-cycle input 0xD.
    out_ready = 1'b0;
    drive('{r: 1'b0, w: 1'b1, wb: 1'b1, dest: 4'd4, alu: 32'hE1, rm: 32'h1}, 1'b1);
    accept_wait("fl_e1");
    drive('{r: 1'b0, w: 1'b1, wb: 1'b1, dest: 4'd5, alu: 32'hE2, rm: 32'h2}, 1'b1);
    accept_wait("fl_e2");
    drive('{r: 1'b1, w: 1'b1, wb: 1'b1, dest: 4'd6, alu: 32'hD, rm: 32'hD}, 1'b1);
    flush = 1'b1;
    step();
    q.delete();
    flush = 1'b0;
    drive(cur, 1'b0);
    @(negedge clk);
    check("fl_full_out_valid", 64'(out_valid), 64'd0);
    check("fl_full_mem_w",     64'(w_out), 64'd0);
    check("fl_full_in_ready",  64'(in_ready), 64'd1);
    check("fl_full_fwd_wb",    64'(fwd_wb_en), 64'd0);
    out_ready = 1'b1;
    repeat (3) step();

    // Flush while ONE with an input that would otherwise be accepted.
    out_ready = 1'b0;
    drive('{r: 1'b1, w: 1'b1, wb: 1'b1, dest: 4'd7, alu: 32'hF1, rm: 32'h3}, 1'b1);
    accept_wait("fl_f1");
    drive('{r: 1'b1, w: 1'b1, wb: 1'b1, dest: 4'd8, alu: 32'hD2, rm: 32'h4}, 1'b1);
    flush = 1'b1;
    step();
    q.delete();
    flush = 1'b0;
    drive(cur, 1'b0);
    @(negedge clk);
    check("fl_one_out_valid", 64'(out_valid), 64'd0);
    check("fl_one_in_ready",  64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();

    // Bubble: asserted control inputs with in_valid low must stay gated.
    drive('{r: 1'b1, w: 1'b1, wb: 1'b1, dest: 4'd15, alu: 32'hBAD, rm: 32'hBAD}, 1'b0);
    step();
    @(negedge clk);
    check("bubble_valid", 64'(out_valid), 64'd0);
    check("bubble_ctrl",  64'({r_out, w_out, wb_out}), 64'd0);
    check("bubble_fwd",   64'(fwd_wb_en), 64'd0);
    step();

    // Single-entry variant: ready follows out_ready combinationally.
    out_ready0 = 1'b0;
    in_valid0  = 1'b1;
    drive('{r: 1'b0, w: 1'b1, wb: 1'b1, dest: 4'd1, alu: 32'h71, rm: 32'h7}, 1'b0);
    @(negedge clk);
    check("s0_empty_ready", 64'(in_ready0), 64'd1);
    step();
    drive('{r: 1'b1, w: 1'b0, wb: 1'b1, dest: 4'd2, alu: 32'h72, rm: 32'h8}, 1'b0);
    @(negedge clk);
    check("s0_held_valid", 64'(out_valid0), 64'd1);
    check("s0_held_ready", 64'(in_ready0), 64'd0);
    check("s0_held_alu",   64'(alu_out0), 64'h71);
    out_ready0 = 1'b1;
    #1;
    check("s0_comb_ready", 64'(in_ready0), 64'd1);
    step();
    in_valid0 = 1'b0;
    @(negedge clk);
    check("s0_replace_valid", 64'(out_valid0), 64'd1);
    check("s0_replace_alu",   64'(alu_out0), 64'h72);
    check("s0_replace_ctrl",  64'({r_out0, w_out0, wb_out0, fwd_dest0}), 64'({1'b1, 1'b0, 1'b1, 4'd2}));
    step();
    @(negedge clk);
    check("s0_drained", 64'({out_valid0, wb_out0, fwd_wb_en0}), 64'd0);
    step();

    check("final_queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_elastic_reg.md
Name: exe_mem_elastic_reg

Overview:
- Parametrised successor to the fixed EXE→MEM pipeline register.
- Carries the memory-stage control bits (MEM_R_EN, MEM_W_EN, WB_EN), Dest, ALU_Res and Val_Rm between EXE and MEM.
- Adds a valid/ready elastic handshake, a 2-entry skid buffer, synchronous flush, and forwarding taps.
- Lets MEM stall (for example on a multi-cycle data memory) without a combinational ready path back into EXE.

Parameters:
- WORD_WIDTH, 32, width of ALU_Res and Val_Rm.
- REG_FILE_DEPTH, 4, width of the Dest register index.
- SKID_EN, 1, 1 = registered in_ready with a 2-entry skid buffer; 0 = single entry with in_ready = out_ready | ~out_valid.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk.
- flush  in  1  discard all held entries (branch taken or exception).
- in_valid  in  1  EXE presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- MEM_R_EN_in, MEM_W_EN_in, WB_EN_in  in  1 each  control bits.
- Dest_in  in  REG_FILE_DEPTH  destination register.
- ALU_Res_in, Val_Rm_in  in  WORD_WIDTH  data.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM accepts the head entry.
- MEM_R_EN_out, MEM_W_EN_out, WB_EN_out  out  1 each  head control, gated by out_valid.
- Dest_out  out  REG_FILE_DEPTH  head destination.
- ALU_Res_out, Val_Rm_out  out  WORD_WIDTH  head data.
- fwd_wb_en  out  1  WB_EN of any valid held entry targeting fwd_dest (head has priority).
- fwd_dest  out  REG_FILE_DEPTH  head Dest (skid Dest when only skid valid: impossible, see invariants).

Behaviour:
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: head register H and skid register S (S exists only when SKID_EN=1); each has a valid bit.
- States:
  - EMPTY: H invalid, S invalid.
  - ONE: H valid, S invalid.
  - FULL: H valid, S valid.
- Invariant: S valid implies H valid.
- in_ready:
  - SKID_EN=1: in_ready = ~S.valid, a pure register output.
  - SKID_EN=0: in_ready = out_ready | ~H.valid.
- Transitions (no flush):
  - EMPTY + in_fire → ONE; H ← input.
  - ONE + in_fire & ~out_fire → FULL; S ← input.
  - ONE + in_fire & out_fire → ONE; H ← input.
  - ONE + ~in_fire & out_fire → EMPTY.
  - FULL + out_fire → ONE; H ← S. in_fire is impossible in FULL because in_ready=0.
  - Any other combination holds state.
- Order is preserved; no entry is duplicated or dropped except by flush.
- Latency: input accepted in cycle N appears on the outputs in cycle N+1 when the stage was EMPTY or draining.
- Throughput: 1 per cycle while out_ready=1.
- Output gating:
  - MEM_R_EN_out, MEM_W_EN_out and WB_EN_out = H field & H.valid, so a bubble never issues a memory access or writeback.
  - Dest_out, ALU_Res_out and Val_Rm_out show H contents regardless of valid.
- Flush:
  - Next cycle: H.valid=0, S.valid=0.
  - Overrides any in_fire in the same cycle (that input is dropped) and any out_fire (the entry is considered consumed; MEM must honour flush identically).
  - in_ready in the cycle after a flush = 1.
- Reset (rst=0 at a clock edge):
  - Both valid bits cleared.
  - All data and control registers = 0.
  - out_valid=0, in_ready=1 from the following cycle.
  - Reset asserted mid-transfer discards everything; reset has priority over flush.
- Forwarding taps:
  - fwd_dest = H.Dest.
  - fwd_wb_en = H.valid & H.WB_EN.
- No arithmetic on data; all widths are pass-through.

Test Plan:
- Reset with rst=0 for 2 cycles, in_valid=1 → out_valid=0, all outputs 0, in_ready=1 after release; no capture during reset.
- Streaming, out_ready=1: inject ALU_Res 0x10, 0x20, 0x30 with Dest 1, 2, 3 back-to-back → each appears exactly 1 cycle later in order, out_valid continuous, in_ready stays 1.
- Backpressure, SKID_EN=1: inject 0xA, 0xB, 0xC while out_ready=0 → 0xA held in H, 0xB in S, in_ready=0 the cycle after 0xB, 0xC held by EXE. Raise out_ready → 0xA, 0xB, 0xC delivered in order, no loss.
- Flush in FULL with a simultaneous in_valid=1 (0xD) → next cycle out_valid=0, MEM_W_EN_out=0, in_ready=1; 0xD is never seen at the output.
- Bubble gating: in_valid=0 with MEM_W_EN_in=1 and WB_EN_in=1 → MEM_W_EN_out=0, WB_EN_out=0, fwd_wb_en=0.
- SKID_EN=0: out_ready=0 with H valid → in_ready=0 in the same cycle. out_ready=1 → in_ready=1 combinationally and a new entry replaces H without a bubble.
